alu_mult_seq: RTL and testbench

- Multi-cycle controller that runs unsigned WIDTH x WIDTH multiplies on the shared ALU slice using shift-add.
- Drives the ALU operand and ALUop lines, and consumes the ALU sum and carry-out.
- Holds a 2*WIDTH product in HI/LO registers for the MULTU/MFHI/MFLO path of the MIPS core.
- Sits beside the main ALU; the core's ALU-source mux grants the ALU to this block while busy=1.

---
 rtl/alu_mult_seq.sv | 113 +++++++++++
 tb/tb_alu_mult_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/alu_mult_seq.sv
// Sequential shift-add unsigned multiplier that borrows the shared ALU slice for
// its partial-sum additions and leaves the 2*WIDTH product in hi/lo.
module alu_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0]       OP_ADD   = 3'b101;
  localparam logic [2:0]       OP_AND   = 3'b000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;

  // One multiply step: optionally add the multiplicand into hi (carry lands in
  // the MSB so partial sums above 2^WIDTH-1 survive), then shift {hi,lo} right.
  function automatic logic [2*WIDTH-1:0] shift_add(
    input logic             add,
    input logic             cout,
    input logic [WIDTH-1:0] sum,
    input logic [WIDTH-1:0] h,
    input logic [WIDTH-1:0] l
  );
    if (add)
      return {cout, sum, l[WIDTH-1:1]};
    else
      return {1'b0, h, l[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = OP_AND;
    case (state)
      IDLE: begin
        if (start)
          state_nxt = CALC;
      end
      CALC: begin
        busy   = 1'b1;
        alu_a  = hi;
        alu_b  = mcand;
        alu_op = OP_ADD;
        if (cnt == CNT_LAST)
          state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= op_a;
            hi    <= '0;
            lo    <= op_b;
            cnt   <= '0;
          end
        end
        CALC: begin
          {hi, lo} <= shift_add(lo[0], alu_cout, alu_sum, hi, lo);
          cnt      <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST)
            done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq: models the shared ALU, runs table and random
// multiplies, and checks timing, ALU drive and hi/lo against plain a*b.
module tb_alu_mult_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  op_a, op_b;
  logic          busy, done;
  logic [W-1:0]  hi, lo;
  logic [W-1:0]  alu_a, alu_b;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_sum;
  logic          alu_cout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Shared ALU slice seen by the block: add for 101, bitwise and otherwise.
  always_comb begin
    if (alu_op == 3'b101)
      {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b};
    else
      {alu_cout, alu_sum} = {1'b0, alu_a & alu_b};
  end

  alu_mult_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_sum(alu_sum), .alu_cout(alu_cout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete multiply. Starts at the next negedge, samples on negedges.
  // mid: pulse start with new operands during CALC; in_done: assert start in DONE.
  task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [63:0] exp, input bit mid, input bit in_done,
                      input string tag);
    int done_at, busy_cnt, op_err, b_err;
    @(negedge clk);
    chk({tag, " idle busy/done"}, {62'd0, busy, done}, 64'd0);
    op_a = a; op_b = b; start = 1'b1;
    done_at = 0; busy_cnt = 0; op_err = 0; b_err = 0;
    for (int n = 1; n <= 40 && done_at == 0; n++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (alu_op !== 3'b101) op_err++;
        if (alu_b !== a) b_err++;
      end else if (alu_op !== 3'b000 || alu_a !== '0 || alu_b !== '0) begin
        op_err++;
      end
      if (done) done_at = n;
      if (n == 1) begin start = 1'b0; op_a = $urandom; op_b = $urandom; end
      if (mid && n == 10) begin start = 1'b1; op_a = $urandom; op_b = $urandom; end
      if (mid && n == 12) start = 1'b0;
    end
    chk({tag, " done cycle"}, 64'(done_at), 64'd33);
    chk({tag, " busy cycles"}, 64'(busy_cnt), 64'd32);
    chk({tag, " alu drive errs"}, 64'(op_err + b_err), 64'd0);
    chk({tag, " product"}, {hi, lo}, exp);
    if (in_done) begin
      start = 1'b1; op_a = 32'd5; op_b = 32'd6;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " start in DONE ignored"}, {62'd0, busy, done}, 64'd0);
      chk({tag, " hold after done"}, {hi, lo}, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [W-1:0] ra, rb;

    tbl[0] = '{32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
    tbl[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{32'h1234_5678,  32'd0,          32'h0,         32'h0};
    tbl[3] = '{32'd0,          32'hFFFF_FFFF,  32'h0,         32'h0};
    tbl[4] = '{32'h8000_0000,  32'd2,          32'h1,         32'h0};
    tbl[5] = '{32'h0001_0000,  32'h0001_0000,  32'h1,         32'h0};

    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("reset busy/done", {62'd0, busy, done}, 64'd0);
    chk("reset hi/lo", {hi, lo}, 64'd0);
    chk("reset alu", {29'd0, alu_op, alu_a}, 64'd0);
    reset = 1'b0;

    // Table vectors back to back: one DONE and one IDLE cycle between runs.
    for (int i = 0; i < 6; i++)
      mult(tbl[i].a, tbl[i].b, {tbl[i].ehi, tbl[i].elo}, 1'b0, 1'b0,
           $sformatf("tbl%0d", i));

    // Start pulses during CALC and in DONE must not disturb the result.
    mult(32'hDEAD_BEEF, 32'h0BAD_F00D, 64'(32'hDEAD_BEEF) * 64'(32'h0BAD_F00D),
         1'b1, 1'b1, "ignore");
    mult(32'd11, 32'd13, 64'd143, 1'b0, 1'b0, "after ignore");

    // Reset in the middle of CALC discards the partial product.
    @(negedge clk);
    op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre-reset busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy/done", {62'd0, busy, done}, 64'd0);
    chk("midreset hi/lo", {hi, lo}, 64'd0);
    chk("midreset alu_op", {61'd0, alu_op}, 64'd0);
    mult(32'd7, 32'd9, 64'h3F, 1'b0, 1'b0, "post-reset");

    // Random operands against a plain 64-bit product.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = ra | 32'hF000_0000;
      if (i % 4 == 2) rb = rb | 32'hF000_0000;
      mult(ra, rb, 64'(ra) * 64'(rb), 1'b0, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
